dmem_access_ctrl: RTL and testbench
===================================

Name: dmem_access_ctrl

Overview:
- Two-requester load/store controller in front of the byte-addressed data memory: requester 0 = core LSU, requester 1 = debug/program loader.
- Arbitrates requests round-robin and converts RV32 sub-word accesses (LB/LH/LW/LBU/LHU, SB/SH/SW) into aligned word accesses on the memory's single 32-bit port.
- The memory only writes full words, so SB/SH are done as read-modify-write. The block also flags misaligned, illegal-funct3 and out-of-range accesses.

Parameters:
- MEM_BYTES, 8192, byte size of the attached memory; legal word addresses satisfy aligned_addr <= MEM_BYTES-4.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  2  bit i = requester i has a request.
- req_ready  out  2  bit i = request i accepted this cycle.
- req_we  in  2  bit i: 1 = store, 0 = load.
- req_funct3  in  6  requester i at [3i+2:3i]; RV32 load/store funct3.
- req_addr  in  64  requester i at [32i+31:32i]; byte address.
- req_wdata  in  64  requester i at [32i+31:32i]; store data, right-justified.
- resp_valid  out  2  bit i = one-cycle response pulse to requester i.
- resp_rdata  out  32  load result, shared; valid only with resp_valid.
- resp_err  out  1  response carries an error, shared; valid only with resp_valid.
- mem_addr  out  32  word-aligned byte address to memory.
- mem_wdata  out  32  full word to write.
- mem_wr_en  out  1  write strobe; memory commits on the falling edge inside the cycle.
- mem_rdata  in  32  combinational read word at mem_addr.

Behaviour:
- Reset (rst high at posedge):
  - state=IDLE, last_grant=1.
  - resp_valid=0, resp_rdata=0, resp_err=0, mem_wr_en=0, mem_addr=0, mem_wdata=0.
  - req_ready forced to 0 while rst is high.
- States: IDLE, ACCESS, WRITE, RESP.
- IDLE / arbitration:
  - grant = the only valid requester; if both are valid, grant = !last_grant.
  - req_ready[grant] = 1 combinationally; the other bit = 0.
  - On valid&&ready, capture id/we/funct3/addr/wdata and set last_grant=id.
  - Requesters hold their fields stable until ready.
- Error check at accept:
  - Misaligned: halfword with addr[0]=1, or word with addr[1:0]!=0.
  - Illegal funct3: loads 3/6/7; stores >=3.
  - Out of range: (addr&~3) > MEM_BYTES-4.
  - Any error -> RESP with err=1, rdata=0. Memory is not touched (mem_wr_en stays 0).
- ACCESS:
  - mem_addr = addr&~3; word = mem_rdata.
  - Load: select byte addr[1:0] or half addr[1]; sign-extend for LB/LH, zero-extend for LBU/LHU; -> RESP.
  - SW: mem_wdata=wdata, mem_wr_en=1; -> RESP.
  - SB/SH: capture word -> WRITE.
- WRITE:
  - mem_addr unchanged; mem_wdata = captured word with the target lane(s) replaced by wdata[7:0] / wdata[15:0]; mem_wr_en=1; -> RESP.
- RESP:
  - resp_valid[id]=1 for exactly one cycle, with registered rdata/err; -> IDLE.
  - No response backpressure.
  - mem_wr_en=0 and mem_addr holds in every state except ACCESS(SW) and WRITE.
- Latency, with handshake in cycle 0:
  - Error -> resp in cycle 1.
  - Load and SW -> resp in cycle 2.
  - SB/SH -> resp in cycle 3.
  - Throughput is one request per 3/4 cycles; new requests are only accepted in IDLE.
- Simultaneous events:
  - A request arriving during a busy transaction waits; the arbitration decision is made in the IDLE cycle, not at arrival.
  - A requester may drop valid before ready without side effect.
- Reset mid-operation:
  - The transaction is dropped with no response.
  - A write whose ACCESS/WRITE cycle began before the reset edge has already committed at that cycle's negedge.
  - No partial RMW write is ever issued after reset.

Test Plan:
- Port0 SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> mem_wr_en pulse in cycle 1; resp_valid[0] in cycle 2; LW returns 0xDEADBEEF, err=0.
- After the above, SB 0x12 data 0x55, then LB 0x12, LBU 0x13, LH 0x12 -> word 0xDE55BEEF; results 0x00000055, 0x000000DE, 0xFFFFDE55; SB resp in cycle 3.
- Port1 LW 0x11, SH 0x13, LW funct3=3, LW addr MEM_BYTES -> each err=1 in cycle 1, rdata=0, mem_wr_en never asserted, memory unchanged.
- Both ports continuously valid (LW) from reset -> grants alternate 0,1,0,1; req_ready pulses exactly once per transaction; each resp_valid goes only to the granted requester.
- Assert rst during the WRITE state of an SB to 0x20 (old word 0x11223344) -> no resp_valid; state back to IDLE; word already written at that negedge reads back with the byte merged; all outputs at reset values.
- Port1 raises valid while port0 is in ACCESS -> port1 accepted in the IDLE cycle after port0's RESP; port0 is not starved on its next request.

Source files
------------

// File: rtl/dmem_access_ctrl.sv
// rtl/dmem_access_ctrl.sv - two-requester RV32 load/store controller with RMW for sub-word stores
//
// Purpose: round-robin arbitration between the core LSU (requester 0) and the
// debug/program loader (requester 1), conversion of LB/LH/LW/LBU/LHU and
// SB/SH/SW into aligned word accesses on a single 32-bit memory port, and
// flagging of misaligned, illegal-funct3 and out-of-range accesses.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   req_valid/req_ready [1:0]     per-requester handshake
//   req_we [1:0]                  1 = store, 0 = load
//   req_funct3 [5:0]              requester i at [3i+2:3i]
//   req_addr, req_wdata [63:0]    requester i at [32i+31:32i]
//   resp_valid [1:0]              one-cycle response pulse per requester
//   resp_rdata [31:0], resp_err   shared response payload
//   mem_addr, mem_wdata, mem_wr_en, mem_rdata   word-wide memory port
module dmem_access_ctrl #(
    parameter int unsigned MEM_BYTES = 8192
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [1:0]  req_we,
    input  logic [5:0]  req_funct3,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic [1:0]  resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_wr_en,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_WRITE,
        S_RESP
    } state_e;

    state_e      state_q, state_d;
    logic        last_grant_q, last_grant_d;
    logic        id_q, id_d;
    logic        we_q, we_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] word_q, word_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;

    logic        grant;
    logic        accept;
    logic        in_we;
    logic [2:0]  in_funct3;
    logic [31:0] in_addr;
    logic [31:0] in_wdata;
    logic        in_err;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_value;
    logic [31:0] merged;
    logic        wr_now;
    logic [31:0] wr_data_now;

    // Arbitration: a lone requester wins; on contention the one not served last wins.
    always_comb begin
        grant     = (req_valid == 2'b11) ? ~last_grant_q : req_valid[1];
        req_ready = 2'b00;
        if (state_q == S_IDLE && !rst && (|req_valid)) begin
            req_ready[grant] = 1'b1;
        end
        accept    = |req_ready;
        in_we     = grant ? req_we[1]         : req_we[0];
        in_funct3 = grant ? req_funct3[5:3]   : req_funct3[2:0];
        in_addr   = grant ? req_addr[63:32]   : req_addr[31:0];
        in_wdata  = grant ? req_wdata[63:32]  : req_wdata[31:0];
    end

    // Access check on the granted request's fields.
    always_comb begin
        in_err = 1'b0;
        if (in_we ? (in_funct3 >= 3'd3)
                  : (in_funct3 == 3'd3 || in_funct3 == 3'd6 || in_funct3 == 3'd7)) begin
            in_err = 1'b1;
        end
        if (in_funct3[1:0] == 2'd1 && in_addr[0]) begin
            in_err = 1'b1;
        end
        if (in_funct3[1:0] == 2'd2 && in_addr[1:0] != 2'b00) begin
            in_err = 1'b1;
        end
        if ({in_addr[31:2], 2'b00} > 32'(MEM_BYTES - 4)) begin
            in_err = 1'b1;
        end
    end

    // Load lane extraction and store lane merge, both keyed off the captured address.
    always_comb begin
        ld_byte = 8'(mem_rdata >> {addr_q[1:0], 3'b000});
        ld_half = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (funct3_q)
            3'd0:    ld_value = {{24{ld_byte[7]}}, ld_byte};
            3'd1:    ld_value = {{16{ld_half[15]}}, ld_half};
            3'd4:    ld_value = {24'd0, ld_byte};
            3'd5:    ld_value = {16'd0, ld_half};
            default: ld_value = mem_rdata;
        endcase

        merged = word_q;
        if (funct3_q[1:0] == 2'd0) begin
            merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
        end else begin
            merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
        end
    end

    // The memory strobe is combinational so SW commits in ACCESS and SB/SH in WRITE.
    always_comb begin
        wr_now      = 1'b0;
        wr_data_now = mem_wdata_q;
        if (state_q == S_ACCESS && we_q && funct3_q == 3'd2) begin
            wr_now      = 1'b1;
            wr_data_now = wdata_q;
        end else if (state_q == S_WRITE) begin
            wr_now      = 1'b1;
            wr_data_now = merged;
        end
    end

    assign mem_wr_en  = wr_now;
    assign mem_wdata  = wr_data_now;
    assign mem_addr   = mem_addr_q;
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;
    assign resp_valid = (state_q == S_RESP) ? (id_q ? 2'b10 : 2'b01) : 2'b00;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        id_d         = id_q;
        we_d         = we_q;
        funct3_d     = funct3_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        word_d       = word_q;
        rdata_d      = rdata_q;
        err_d        = err_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = wr_data_now;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    id_d         = grant;
                    we_d         = in_we;
                    funct3_d     = in_funct3;
                    addr_d       = in_addr;
                    wdata_d      = in_wdata;
                    last_grant_d = grant;
                    rdata_d      = 32'd0;
                    err_d        = in_err;
                    if (in_err) begin
                        state_d = S_RESP;
                    end else begin
                        mem_addr_d = {in_addr[31:2], 2'b00};
                        state_d    = S_ACCESS;
                    end
                end
            end
            S_ACCESS: begin
                if (!we_q) begin
                    rdata_d = ld_value;
                    state_d = S_RESP;
                end else if (funct3_q == 3'd2) begin
                    state_d = S_RESP;
                end else begin
                    word_d  = mem_rdata;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            id_q         <= 1'b0;
            we_q         <= 1'b0;
            funct3_q     <= 3'd0;
            addr_q       <= 32'd0;
            wdata_q      <= 32'd0;
            word_q       <= 32'd0;
            rdata_q      <= 32'd0;
            err_q        <= 1'b0;
            mem_addr_q   <= 32'd0;
            mem_wdata_q  <= 32'd0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            id_q         <= id_d;
            we_q         <= we_d;
            funct3_q     <= funct3_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            word_q       <= word_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb/tb_dmem_access_ctrl.sv - self-checking bench for dmem_access_ctrl
module tb_dmem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [1:0]  req_we;
    logic [5:0]  req_funct3;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic [1:0]  resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_wr_en;
    logic [31:0] mem_rdata;

    logic [31:0] mem [0:2047];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dmem_access_ctrl #(.MEM_BYTES(8192)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wr_en  (mem_wr_en),
        .mem_rdata  (mem_rdata)
    );

    assign mem_rdata = mem[mem_addr[12:2]];

    always @(negedge clk) begin
        if (mem_wr_en) mem[mem_addr[12:2]] <= mem_wdata;
    end

    typedef struct {
        logic        port;
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_err;
        logic [31:0] exp_rdata;
        int          exp_lat;
        int          exp_wr;
    } vec_t;

    vec_t vecs [21];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic port, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata);
        if (port) begin
            req_we[1] = we; req_funct3[5:3] = f3; req_addr[63:32] = addr; req_wdata[63:32] = wdata;
        end else begin
            req_we[0] = we; req_funct3[2:0] = f3; req_addr[31:0] = addr; req_wdata[31:0] = wdata;
        end
        req_valid[port] = 1'b1;
    endtask

    // Issues one request and returns response latency from the handshake cycle.
    task automatic do_req(input logic port, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output int lat, output logic [31:0] rdata, output logic err,
                          output int wr, output logic [1:0] rv);
        bit got_ready;
        lat = 0; rdata = 'x; err = 'x; wr = 0; rv = 2'b00;
        got_ready = 0;
        @(negedge clk);
        drive(port, we, f3, addr, wdata);
        for (int k = 0; k < 10; k++) begin
            if (req_ready[port]) begin
                got_ready = 1;
                break;
            end
            @(negedge clk);
        end
        if (!got_ready) begin
            check("ready_timeout", 32'd0, 32'd1);
            req_valid = 2'b00;
            return;
        end
        @(posedge clk);
        #1 req_valid = 2'b00;
        for (int c = 1; c < 8; c++) begin
            @(negedge clk);
            if (mem_wr_en) wr++;
            if (resp_valid != 2'b00) begin
                lat = c; rdata = resp_rdata; err = resp_err; rv = resp_valid;
                break;
            end
        end
    endtask

    initial begin
        int          lat, wr, ngr, nrsp;
        logic [31:0] rd;
        logic        er;
        logic [1:0]  rv;
        logic        exp_g;
        logic [1:0]  last_g;

        vecs[0]  = '{1'b0, 1'b1, 3'd2, 32'h10,   32'hDEADBEEF, 1'b0, 32'h0,        2, 1};
        vecs[1]  = '{1'b0, 1'b0, 3'd2, 32'h10,   32'h0,        1'b0, 32'hDEADBEEF, 2, 0};
        vecs[2]  = '{1'b0, 1'b1, 3'd0, 32'h12,   32'h55,       1'b0, 32'h0,        3, 1};
        vecs[3]  = '{1'b0, 1'b0, 3'd0, 32'h12,   32'h0,        1'b0, 32'h00000055, 2, 0};
        vecs[4]  = '{1'b0, 1'b0, 3'd4, 32'h13,   32'h0,        1'b0, 32'h000000DE, 2, 0};
        vecs[5]  = '{1'b0, 1'b0, 3'd1, 32'h12,   32'h0,        1'b0, 32'hFFFFDE55, 2, 0};
        vecs[6]  = '{1'b0, 1'b0, 3'd2, 32'h10,   32'h0,        1'b0, 32'hDE55BEEF, 2, 0};
        vecs[7]  = '{1'b1, 1'b0, 3'd2, 32'h11,   32'h0,        1'b1, 32'h0,        1, 0};
        vecs[8]  = '{1'b1, 1'b1, 3'd1, 32'h13,   32'hFFFF,     1'b1, 32'h0,        1, 0};
        vecs[9]  = '{1'b1, 1'b0, 3'd3, 32'h10,   32'h0,        1'b1, 32'h0,        1, 0};
        vecs[10] = '{1'b1, 1'b0, 3'd2, 32'h2000, 32'h0,        1'b1, 32'h0,        1, 0};
        vecs[11] = '{1'b1, 1'b0, 3'd2, 32'h10,   32'h0,        1'b0, 32'hDE55BEEF, 2, 0};
        vecs[12] = '{1'b1, 1'b1, 3'd1, 32'h16,   32'hABCD1234, 1'b0, 32'h0,        3, 1};
        vecs[13] = '{1'b1, 1'b0, 3'd5, 32'h16,   32'h0,        1'b0, 32'h00001234, 2, 0};
        vecs[14] = '{1'b0, 1'b1, 3'd0, 32'h14,   32'h180,      1'b0, 32'h0,        3, 1};
        vecs[15] = '{1'b0, 1'b0, 3'd0, 32'h14,   32'h0,        1'b0, 32'hFFFFFF80, 2, 0};
        vecs[16] = '{1'b0, 1'b0, 3'd4, 32'h14,   32'h0,        1'b0, 32'h00000080, 2, 0};
        vecs[17] = '{1'b1, 1'b0, 3'd2, 32'h1FFC, 32'h0,        1'b0, 32'h0,        2, 0};
        vecs[18] = '{1'b1, 1'b1, 3'd3, 32'h18,   32'h12345678, 1'b1, 32'h0,        1, 0};
        vecs[19] = '{1'b0, 1'b0, 3'd2, 32'h14,   32'h0,        1'b0, 32'h12340080, 2, 0};
        vecs[20] = '{1'b0, 1'b0, 3'd6, 32'h10,   32'h0,        1'b1, 32'h0,        1, 0};

        for (int i = 0; i < 2048; i++) mem[i] = 32'h0;
        mem[8] = 32'h11223344;

        // Reset with both requesters asserting valid: ready must stay low.
        rst = 1'b1; req_valid = 2'b11; req_we = 2'b00; req_funct3 = 6'b010010;
        req_addr = {32'h14, 32'h10}; req_wdata = 64'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_resp_err", 32'(resp_err), 32'd0);
        check("rst_mem_wr_en", 32'(mem_wr_en), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        req_valid = 2'b00;
        @(posedge clk);
        #1 rst = 1'b0;

        foreach (vecs[i]) begin
            do_req(vecs[i].port, vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata,
                   lat, rd, er, wr, rv);
            check($sformatf("v%0d_lat", i), 32'(lat), 32'(vecs[i].exp_lat));
            check($sformatf("v%0d_err", i), 32'(er), 32'(vecs[i].exp_err));
            check($sformatf("v%0d_wr_cnt", i), 32'(wr), 32'(vecs[i].exp_wr));
            check($sformatf("v%0d_resp_id", i), 32'(rv), vecs[i].port ? 32'd2 : 32'd1);
            if (!vecs[i].we || vecs[i].exp_err)
                check($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rdata);
        end

        // Port1 arrives while port0 is busy; decided in the next IDLE, then port0 wins.
        @(negedge clk);
        drive(1'b0, 1'b0, 3'd2, 32'h10, 32'h0);
        @(posedge clk);
        #1 req_valid = 2'b00;
        drive(1'b1, 1'b0, 3'd2, 32'h14, 32'h0);
        @(negedge clk);
        check("busy_c1_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        check("busy_c2_ready", 32'(req_ready), 32'd0);
        check("busy_c2_resp", 32'(resp_valid), 32'd1);
        check("busy_c2_rdata", resp_rdata, 32'hDE55BEEF);
        @(negedge clk);
        check("busy_c3_ready", 32'(req_ready), 32'd2);
        @(posedge clk);
        #1 drive(1'b0, 1'b0, 3'd2, 32'h10, 32'h0);
        @(negedge clk);
        @(negedge clk);
        check("busy_c5_resp", 32'(resp_valid), 32'd2);
        check("busy_c5_rdata", resp_rdata, 32'h12340080);
        @(negedge clk);
        check("busy_c6_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1 req_valid = 2'b00;
        @(negedge clk);
        @(negedge clk);
        check("busy_c8_resp", 32'(resp_valid), 32'd1);

        // Both ports continuously valid from reset: grants alternate 0,1,0,1.
        @(posedge clk);
        #1 rst = 1'b1;
        drive(1'b0, 1'b0, 3'd2, 32'h10, 32'h0);
        drive(1'b1, 1'b0, 3'd2, 32'h14, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        ngr = 0; nrsp = 0; exp_g = 1'b0; last_g = 2'b00;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (req_ready != 2'b00) begin
                check($sformatf("alt_grant%0d", ngr), 32'(req_ready), exp_g ? 32'd2 : 32'd1);
                last_g = req_ready;
                exp_g  = ~exp_g;
                ngr++;
            end
            if (resp_valid != 2'b00) begin
                check($sformatf("alt_resp%0d", nrsp), 32'(resp_valid), 32'(last_g));
                check($sformatf("alt_rdata%0d", nrsp), resp_rdata,
                      resp_valid[1] ? 32'h12340080 : 32'hDE55BEEF);
                nrsp++;
            end
        end
        check("alt_ready_count", 32'(ngr), 32'd4);
        check("alt_resp_count", 32'(nrsp), 32'd4);
        @(posedge clk);
        #1 req_valid = 2'b00;

        // Reset during the WRITE cycle of SB 0x20.
        @(negedge clk);
        drive(1'b0, 1'b1, 3'd0, 32'h20, 32'hAA);
        @(posedge clk);
        #1 req_valid = 2'b00;
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("rmw_wr_en", 32'(mem_wr_en), 32'd1);
        check("rmw_wdata", mem_wdata, 32'h112233AA);
        @(posedge clk);
        #1;
        check("rmw_rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rmw_rst_wr_en", 32'(mem_wr_en), 32'd0);
        check("rmw_rst_mem_addr", mem_addr, 32'd0);
        check("rmw_rst_mem_wdata", mem_wdata, 32'd0);
        check("rmw_rst_rdata", resp_rdata, 32'd0);
        check("rmw_rst_err", 32'(resp_err), 32'd0);
        check("rmw_mem_word", mem[8], 32'h112233AA);
        rst = 1'b0;
        nrsp = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (resp_valid != 2'b00) nrsp++;
        end
        check("rmw_no_resp", 32'(nrsp), 32'd0);
        do_req(1'b0, 1'b0, 3'd2, 32'h20, 32'h0, lat, rd, er, wr, rv);
        check("rmw_readback", rd, 32'h112233AA);
        check("rmw_readback_lat", 32'(lat), 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
